// File: rtl/stack_cpu_fetch_decode.sv
// rtl/stack_cpu_fetch_decode.sv - fetch/decode/issue sequencer for the stack CPU
// Purpose: fetches 16-bit instructions from program memory, decodes opcode and
// immediate, tracks operand-stack depth and issues one operation at a time to
// the stack/ALU datapath over a valid/ready handshake.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   run_i                              start execution from pc 0 (IDLE only)
//   pc_o / instr_i                     program memory address / data (1-cycle latency)
//   op_valid_o, op_ready_i             issue handshake to the datapath
//   opcode_o, imm_o                    decoded opcode / sign-extended PUSH immediate
//   depth_o                            tracked operand-stack depth
//   busy_o, halted_o                   executing / HALT_CPU reached
//   fault_o, fault_code_o              sticky fault and its cause
// Build option: STACKCPU_ILLEGAL_TRAP_EN makes opcodes 01001-11110 fault with
// code 11; without it they execute as NOPs.
module stack_cpu_fetch_decode #(
  parameter int DATA_WIDTH     = 32,
  parameter int STACK_DEPTH    = 16,
  parameter int INSTR_WIDTH    = 16,
  parameter int PGRM_MEM_DEPTH = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run_i,
  output logic [$clog2(PGRM_MEM_DEPTH)-1:0]  pc_o,
  input  logic [INSTR_WIDTH-1:0]             instr_i,
  output logic                               op_valid_o,
  input  logic                               op_ready_i,
  output logic [4:0]                         opcode_o,
  output logic [DATA_WIDTH-1:0]              imm_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
  output logic                               busy_o,
  output logic                               halted_o,
  output logic                               fault_o,
  output logic [1:0]                         fault_code_o
);

  localparam int PC_W  = $clog2(PGRM_MEM_DEPTH);
  localparam int DEP_W = $clog2(STACK_DEPTH+1);
  localparam int IMM_W = INSTR_WIDTH - 5;

  localparam logic [4:0]       OP_PUSH     = 5'b00000;
  localparam logic [4:0]       OP_LAST_BIN = 5'b00111;
  localparam logic [4:0]       OP_INVERT   = 5'b01000;
  localparam logic [4:0]       OP_HALT     = 5'b11111;
  localparam logic [DEP_W-1:0] STACK_MAX   = DEP_W'(STACK_DEPTH);

`ifdef STACKCPU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALTED, S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]       pc_q;
  logic [DEP_W-1:0]      depth_q;
  logic [4:0]            opcode_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [1:0]            fault_code_q;

  // Decode works directly on instr_i, which is valid during DECODE because
  // pc_o was presented during the preceding FETCH cycle.
  logic [4:0] dec_op;
  logic       dec_fault;
  logic [1:0] dec_code;
  logic       dec_halt;
  logic       dec_illegal;

  assign dec_op = instr_i[INSTR_WIDTH-1 -: 5];

  always_comb begin
    dec_fault   = 1'b0;
    dec_code    = 2'b00;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    if (dec_op == OP_PUSH) begin
      if (depth_q >= STACK_MAX) begin
        dec_fault = 1'b1;
        dec_code  = 2'b10;
      end
    end else if (dec_op <= OP_LAST_BIN) begin
      if (depth_q < DEP_W'(2)) begin
        dec_fault = 1'b1;
        dec_code  = 2'b01;
      end
    end else if (dec_op == OP_INVERT) begin
      if (depth_q == '0) begin
        dec_fault = 1'b1;
        dec_code  = 2'b01;
      end
    end else if (dec_op == OP_HALT) begin
      dec_halt = 1'b1;
    end else begin
      dec_illegal = 1'b1;
      if (TRAP_EN) begin
        dec_fault = 1'b1;
        dec_code  = 2'b11;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_halt)         state_d = S_HALTED;
        else if (dec_fault)   state_d = S_FAULT;
        else if (dec_illegal) state_d = S_FETCH;
        else                  state_d = S_ISSUE;
      end
      S_ISSUE:  if (op_ready_i) state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // PC, depth and decoded-operation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      depth_q      <= '0;
      opcode_q     <= '0;
      imm_q        <= '0;
      fault_code_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_i) begin
            pc_q    <= '0;
            depth_q <= '0;
          end
        end
        S_DECODE: begin
          opcode_q <= dec_op;
          imm_q    <= (dec_op == OP_PUSH) ?
                      {{(DATA_WIDTH-IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]} : '0;
          if (dec_fault)        fault_code_q <= dec_code;
          else if (dec_illegal) pc_q         <= pc_q + 1'b1;
        end
        S_ISSUE: begin
          if (op_ready_i) begin
            // pc wraps naturally at the top of program memory
            pc_q <= pc_q + 1'b1;
            if (opcode_q == OP_PUSH)          depth_q <= depth_q + 1'b1;
            else if (opcode_q <= OP_LAST_BIN) depth_q <= depth_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    op_valid_o = (state_q == S_ISSUE);
    busy_o     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
    halted_o   = (state_q == S_HALTED);
    fault_o    = (state_q == S_FAULT);
  end

  assign pc_o         = pc_q;
  assign depth_o      = depth_q;
  assign opcode_o     = opcode_q;
  assign imm_o        = imm_q;
  assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_stack_cpu_fetch_decode.sv
// tb/tb_stack_cpu_fetch_decode.sv - self-checking bench for stack_cpu_fetch_decode
module tb_stack_cpu_fetch_decode;

  localparam logic [15:0] HALT_W = 16'hF800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_i;
  logic [7:0]  pc_o;
  logic [15:0] instr_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [4:0]  opcode_o;
  logic [31:0] imm_o;
  logic [4:0]  depth_o;
  logic        busy_o;
  logic        halted_o;
  logic        fault_o;
  logic [1:0]  fault_code_o;

  always #5 clk = ~clk;

  stack_cpu_fetch_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_i),
    .pc_o         (pc_o),
    .instr_i      (instr_i),
    .op_valid_o   (op_valid_o),
    .op_ready_i   (op_ready_i),
    .opcode_o     (opcode_o),
    .imm_o        (imm_o),
    .depth_o      (depth_o),
    .busy_o       (busy_o),
    .halted_o     (halted_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o)
  );

  // Program memory with one cycle of read latency
  logic [15:0] mem [0:255];
  always @(posedge clk) instr_i <= mem[pc_o];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] imm;
    int          dep;
  } op_t;

  op_t exp_q[$];
  op_t got_q[$];
  int  m_halt, m_code, m_pc, m_dep;
  int  stab_err, mul_valid, mul_dep_err;

  typedef struct {
    logic [15:0] p0, p1, p2, p3;
    int exp_halt, exp_code, exp_pc, exp_dep, exp_cyc;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d,
                              input int eh, ec, ep, ed, ecyc);
    vec_t v;
    v.p0 = a; v.p1 = b; v.p2 = c; v.p3 = d;
    v.exp_halt = eh; v.exp_code = ec; v.exp_pc = ep; v.exp_dep = ed; v.exp_cyc = ecyc;
    return v;
  endfunction

  // Instruction-level interpreter of the program in mem
  task automatic model_run();
    int pc;
    int d;
    logic [15:0] w;
    logic [4:0]  op;
    op_t r;
    pc = 0; d = 0;
    exp_q.delete();
    m_halt = 0; m_code = 0;
    for (int s = 0; s < 10000; s++) begin
      w = mem[pc];
      op = w[15:11];
      r.opc = op; r.dep = d; r.imm = 32'd0;
      if (op == 5'd0) begin
        if (d >= 16) begin m_code = 2; break; end
        r.imm = {{21{w[10]}}, w[10:0]};
        exp_q.push_back(r); d++; pc = (pc + 1) % 256;
      end else if (op <= 5'd7) begin
        if (d < 2) begin m_code = 1; break; end
        exp_q.push_back(r); d--; pc = (pc + 1) % 256;
      end else if (op == 5'd8) begin
        if (d < 1) begin m_code = 1; break; end
        exp_q.push_back(r); pc = (pc + 1) % 256;
      end else if (op == 5'd31) begin
        m_halt = 1; break;
      end else begin
`ifdef STACKCPU_ILLEGAL_TRAP_EN
        m_code = 3; break;
`else
        pc = (pc + 1) % 256;
`endif
      end
    end
    m_pc = pc; m_dep = d;
  endtask

  // mode 0: ready always high; 1: random ready/run_i; 2: stall MUL 4 cycles
  task automatic run_dut(input string tag, input int mode, input int max_cyc, output int cyc);
    int stall;
    bit have_prev;
    logic [4:0]  prev_opc;
    logic [31:0] prev_imm;
    op_t r;
    got_q.delete();
    stab_err = 0; mul_valid = 0; mul_dep_err = 0; stall = 0; have_prev = 0;
    prev_opc = '0; prev_imm = '0;
    rst_n = 1'b0; run_i = 1'b0; op_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    cyc = 0;
    while (!(halted_o || fault_o) && cyc < max_cyc) begin
      case (mode)
        1: begin
          op_ready_i = 1'($urandom_range(0, 1));
          run_i      = 1'($urandom_range(0, 1));
        end
        2: begin
          if (op_valid_o && opcode_o == 5'd3 && stall < 4) begin
            op_ready_i = 1'b0; stall++;
          end else op_ready_i = 1'b1;
        end
        default: op_ready_i = 1'b1;
      endcase
      if (op_valid_o) begin
        if (have_prev && (opcode_o != prev_opc || imm_o != prev_imm)) stab_err++;
        if (opcode_o == 5'd3) begin
          mul_valid++;
          if (depth_o != 5'd2) mul_dep_err++;
        end
        if (op_ready_i) begin
          r.opc = opcode_o; r.imm = imm_o; r.dep = int'(depth_o);
          got_q.push_back(r);
          have_prev = 0;
        end else begin
          have_prev = 1; prev_opc = opcode_o; prev_imm = imm_o;
        end
      end
      @(negedge clk);
      cyc++;
    end
    run_i = 1'b0;
    chk({tag, " terminated"}, halted_o || fault_o, 1);
    chk({tag, " stable"}, stab_err, 0);
  endtask

  task automatic cmp_ops(input string tag);
    chk({tag, " nops"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " opc"}, got_q[i].opc, exp_q[i].opc);
      chk({tag, " imm"}, got_q[i].imm, exp_q[i].imm);
      chk({tag, " dep"}, got_q[i].dep, exp_q[i].dep);
    end
  endtask

  task automatic chk_final(input string tag, input int eh, ec, ep, ed);
    chk({tag, " halted"}, halted_o, eh);
    chk({tag, " fault"}, fault_o, (ec != 0));
    chk({tag, " code"}, fault_code_o, ec);
    chk({tag, " pc"}, pc_o, ep);
    chk({tag, " depth"}, depth_o, ed);
    chk({tag, " valid"}, op_valid_o, 0);
    chk({tag, " busy"}, busy_o, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"}, pc_o, 0);
    chk({tag, " valid"}, op_valid_o, 0);
    chk({tag, " opcode"}, opcode_o, 0);
    chk({tag, " imm"}, imm_o, 0);
    chk({tag, " depth"}, depth_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " halted"}, halted_o, 0);
    chk({tag, " fault"}, fault_o, 0);
    chk({tag, " code"}, fault_code_o, 0);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = HALT_W;
  endtask

  vec_t vecs[8];
  int cyc, n, len, k;
  logic [15:0] w;

  initial begin
    vecs[0] = mk(16'h0005, 16'h07FD, 16'h0800, HALT_W, 1, 0, 3, 1, 11);
    vecs[1] = mk(16'h0800, HALT_W,   HALT_W,   HALT_W, 0, 1, 0, 0, 2);
    vecs[2] = mk(16'h0001, 16'h4000, 16'h4000, HALT_W, 1, 0, 3, 1, 11);
    vecs[3] = mk(16'h4000, HALT_W,   HALT_W,   HALT_W, 0, 1, 0, 0, 2);
    vecs[4] = mk(16'h0001, 16'h1000, HALT_W,   HALT_W, 0, 1, 1, 1, 5);
    vecs[5] = mk(HALT_W,   16'h0001, HALT_W,   HALT_W, 1, 0, 0, 0, 2);
`ifdef STACKCPU_ILLEGAL_TRAP_EN
    vecs[6] = mk(16'h4800, 16'h0007, HALT_W,   HALT_W, 0, 3, 0, 0, 2);
`else
    vecs[6] = mk(16'h4800, 16'h0007, HALT_W,   HALT_W, 1, 0, 2, 1, 7);
`endif
    vecs[7] = mk(16'h03FF, 16'h0400, 16'h3800, HALT_W, 1, 0, 3, 1, 11);

    // Reset values, and run_i absent keeps the sequencer idle
    clear_mem();
    rst_n = 1'b0; run_i = 1'b0; op_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle busy", busy_o, 0);
    chk("idle pc", pc_o, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      clear_mem();
      mem[0] = vecs[i].p0; mem[1] = vecs[i].p1; mem[2] = vecs[i].p2; mem[3] = vecs[i].p3;
      model_run();
      run_dut($sformatf("vec%0d", i), 0, 200, cyc);
      chk_final($sformatf("vec%0d", i), vecs[i].exp_halt, vecs[i].exp_code,
                vecs[i].exp_pc, vecs[i].exp_dep);
      chk($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cyc);
      cmp_ops($sformatf("vec%0d", i));
    end

    // 17 consecutive PUSH 1: overflow on the 17th
    clear_mem();
    for (int a = 0; a < 17; a++) mem[a] = 16'h0001;
    model_run();
    run_dut("ovf", 1, 500, cyc);
    chk_final("ovf", 0, 2, 16, 16);
    cmp_ops("ovf");

    // MUL held off for 4 cycles
    clear_mem();
    mem[0] = 16'h0002; mem[1] = 16'h0003; mem[2] = 16'h1800;
    model_run();
    run_dut("mul", 2, 200, cyc);
    chk("mul valid cycles", mul_valid, 5);
    chk("mul depth held", mul_dep_err, 0);
    chk_final("mul", 1, 0, 3, 1);
    cmp_ops("mul");

    // PC wrap: no HALT anywhere, runs through 255 -> 0 until overflow
    for (int a = 0; a < 256; a++) mem[a] = (a < 2 || a % 2 == 1) ? 16'h0001 : 16'h0800;
    model_run();
    run_dut("wrap", 0, 20000, cyc);
    chk_final("wrap", m_halt, m_code, m_pc, m_dep);
    cmp_ops("wrap");

    // Reset while an operation is being offered
    clear_mem();
    mem[0] = 16'h0123;
    rst_n = 1'b0; run_i = 1'b0; op_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    n = 0;
    while (!op_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("rst valid seen", op_valid_o, 1);
    repeat (2) @(negedge clk);
    chk("rst valid held", op_valid_o, 1);
    chk("rst imm", imm_o, 32'h0000_0123);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    model_run();
    run_dut("restart", 0, 200, cyc);
    chk_final("restart", 1, 0, 1, 1);
    cmp_ops("restart");

    // Randomized programs against the interpreter
    for (int t = 0; t < 12; t++) begin
      clear_mem();
      len = $urandom_range(1, 40);
      for (int a = 0; a < len; a++) begin
        k = $urandom_range(0, 99);
        if (k < 45)      w = {5'd0, 11'($urandom)};
        else if (k < 75) w = {5'($urandom_range(1, 7)), 11'($urandom)};
        else if (k < 85) w = {5'd8, 11'($urandom)};
        else if (k < 95) w = {5'($urandom_range(9, 30)), 11'($urandom)};
        else             w = HALT_W;
        mem[a] = w;
      end
      model_run();
      run_dut($sformatf("rnd%0d", t), 1, 2000, cyc);
      chk_final($sformatf("rnd%0d", t), m_halt, m_code, m_pc, m_dep);
      cmp_ops($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
